// File: rtl/axi_to_ndata_typed_buffered.sv
// axi_to_ndata_typed_buffered: registered unpacker from a 64*NUM_ELEMENTS-bit
// AXI stream to a NUM_ELEMENTS x 64-bit ndata stream (32- or 64-bit elements).
// Ports: clk, rst_n (async active-low); type_width_i (BIT32/BIT64);
//   in_tdata_i/in_tkeep_i/in_tlast_i/in_tvalid_i/in_tready_o (AXI4S slave);
//   out_data_o/out_keep_o/out_last_o/out_valid_o/out_ready_i (ndata master).
// Optional: `define AXI_TO_NDATA_SIGN_EXT_EN sign-extends BIT32 elements.
package axi_to_ndata_typed_buffered_pkg;
    typedef enum logic {
        BIT32 = 1'b0,
        BIT64 = 1'b1
    } type_width_t;
endpackage

module axi_to_ndata_typed_buffered
    import axi_to_ndata_typed_buffered_pkg::*;
#(
    parameter int NUM_ELEMENTS = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  type_width_t                        type_width_i,
    input  logic [64*NUM_ELEMENTS-1:0]         in_tdata_i,
    input  logic [8*NUM_ELEMENTS-1:0]          in_tkeep_i,
    input  logic                               in_tlast_i,
    input  logic                               in_tvalid_i,
    output logic                               in_tready_o,
    output logic [NUM_ELEMENTS-1:0][63:0]      out_data_o,
    output logic [NUM_ELEMENTS-1:0]            out_keep_o,
    output logic                               out_last_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i
);
    localparam int N = NUM_ELEMENTS;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LO,
        S_HI
    } state_t;

    state_t              state_q, state_d;
    logic [64*N-1:0]     data_q;
    // keep_q[j] is the lowest keep bit of 32-bit word j; a 64-bit element i
    // uses word 2i, so one compressed vector serves both widths.
    logic [2*N-1:0]      keep_q, keep_sel;
    logic                upper_q;
    logic                last_q;
    logic                w64_q;

    logic fire, accept, lo_final, beat_done;
    logic unused_tkeep;

    function automatic logic [63:0] ext32(input logic [31:0] w);
`ifdef AXI_TO_NDATA_SIGN_EXT_EN
        return {{32{w[31]}}, w};
`else
        return {32'h0, w};
`endif
    endfunction

    always_comb begin
        keep_sel = '0;
        for (int j = 0; j < 2*N; j++) begin
            keep_sel[j] = in_tkeep_i[4*j];
        end
    end

    assign unused_tkeep = ^in_tkeep_i;

    // An LO sub-beat ends the beat unless a BIT32 upper half carries data.
    assign lo_final  = w64_q || !upper_q;
    assign fire      = out_valid_o && out_ready_i;
    assign beat_done = fire && ((state_q == S_HI) ||
                                (state_q == S_LO && lo_final));
    assign in_tready_o = (state_q == S_EMPTY) || beat_done;
    assign accept      = in_tvalid_i && in_tready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            keep_q  <= '0;
            upper_q <= 1'b0;
            last_q  <= 1'b0;
            w64_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q  <= in_tdata_i;
                keep_q  <= keep_sel;
                upper_q <= |in_tkeep_i[8*N-1:4*N];
                last_q  <= in_tlast_i;
                w64_q   <= (type_width_i == BIT64);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = S_LO;
        end else if (beat_done) begin
            state_d = S_EMPTY;
        end else if (fire && state_q == S_LO) begin
            state_d = S_HI;
        end
    end

    always_comb begin
        out_valid_o = (state_q != S_EMPTY);
        out_last_o  = last_q && ((state_q == S_HI) ||
                                 (state_q == S_LO && lo_final));
        out_data_o  = '0;
        out_keep_o  = '0;
        for (int i = 0; i < N; i++) begin
            if (w64_q) begin
                out_data_o[i] = data_q[64*i +: 64];
                out_keep_o[i] = keep_q[2*i];
            end else if (state_q == S_HI) begin
                out_data_o[i] = ext32(data_q[32*(i+N) +: 32]);
                out_keep_o[i] = keep_q[i+N];
            end else begin
                out_data_o[i] = ext32(data_q[32*i +: 32]);
                out_keep_o[i] = keep_q[i];
            end
        end
    end

endmodule

// File: tb/tb_axi_to_ndata_typed_buffered.sv
// tb_axi_to_ndata_typed_buffered: randomized + directed self-checking bench
// with a queue-based sub-beat reference model.
module tb_axi_to_ndata_typed_buffered;
    import axi_to_ndata_typed_buffered_pkg::*;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0][63:0] data;
        logic [N-1:0]       keep;
        logic               last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    type_width_t           tw = BIT64;
    logic [64*N-1:0]       tdata = '0;
    logic [8*N-1:0]        tkeep = '0;
    logic                  tlast = 1'b0;
    logic                  tvalid = 1'b0;
    logic                  tready;
    logic [N-1:0][63:0]    out_data;
    logic [N-1:0]          out_keep;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready = 1'b1;

    int    n_chk  = 0;
    int    n_pass = 0;
    int    rmode  = 0;
    int    tog    = 0;
    beat_t exp_q[$];
    beat_t held;
    logic  stalled = 1'b0;

    axi_to_ndata_typed_buffered #(.NUM_ELEMENTS(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .type_width_i (tw),
        .in_tdata_i   (tdata),
        .in_tkeep_i   (tkeep),
        .in_tlast_i   (tlast),
        .in_tvalid_i  (tvalid),
        .in_tready_o  (tready),
        .out_data_o   (out_data),
        .out_keep_o   (out_keep),
        .out_last_o   (out_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1023:0] got,
                         input logic [1023:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] ext(input logic [31:0] w);
`ifdef AXI_TO_NDATA_SIGN_EXT_EN
        return {{32{w[31]}}, w};
`else
        return {32'h0, w};
`endif
    endfunction

    // Expand one accepted AXI beat into the ndata sub-beats it must produce.
    task automatic model_accept(input logic [64*N-1:0] d,
                                input logic [8*N-1:0] k,
                                input logic l, input type_width_t t);
        beat_t b;
        logic  has_hi;
        if (t == BIT64) begin
            for (int i = 0; i < N; i++) begin
                b.data[i] = d[64*i +: 64];
                b.keep[i] = k[8*i];
            end
            b.last = l;
            exp_q.push_back(b);
        end else begin
            has_hi = (k[8*N-1:4*N] != '0);
            for (int i = 0; i < N; i++) begin
                b.data[i] = ext(d[32*i +: 32]);
                b.keep[i] = k[4*i];
            end
            b.last = l && !has_hi;
            exp_q.push_back(b);
            if (has_hi) begin
                for (int i = 0; i < N; i++) begin
                    b.data[i] = ext(d[32*N + 32*i +: 32]);
                    b.keep[i] = k[4*N + 4*i];
                end
                b.last = l;
                exp_q.push_back(b);
            end
        end
    endtask

    // One clock: called right after a negedge, returns at the next one.
    task automatic step(output logic acc);
        beat_t got, e;
        logic  exp_rdy;
        case (rmode)
            0: out_ready = 1'b1;
            1: begin out_ready = tog[0]; tog++; end
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
        #1;
        got.data = out_data;
        got.keep = out_keep;
        got.last = out_last;
        exp_rdy = (exp_q.size() == 0) ||
                  (exp_q.size() == 1 && out_ready);
        check("valid", 1024'(out_valid), 1024'(exp_q.size() != 0));
        check("tready", 1024'(tready), 1024'(exp_rdy));
        if (stalled && out_valid) check("stable", 1024'(got), 1024'(held));
        if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat", 1024'(got), 1024'(e));
        end
        stalled = out_valid && !out_ready;
        held = got;
        acc = tvalid && tready;
        if (acc) model_accept(tdata, tkeep, tlast, tw);
        @(negedge clk);
    endtask

    task automatic send(input logic [64*N-1:0] d, input logic [8*N-1:0] k,
                        input logic l, input type_width_t t);
        logic acc;
        int   g;
        g = 0;
        tvalid = 1'b1; tdata = d; tkeep = k; tlast = l; tw = t;
        do begin
            step(acc);
            g++;
        end while (!acc && g < 50);
        if (!acc) check("accept_timeout", 1024'(0), 1024'(1));
        tvalid = 1'b0;
        // The held beat must keep its captured width.
        tw = (t == BIT64) ? BIT32 : BIT64;
    endtask

    task automatic drain();
        logic acc;
        int   g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            step(acc);
            g++;
        end
        if (exp_q.size() != 0)
            check("drain_timeout", 1024'(exp_q.size()), 1024'(0));
    endtask

    function automatic logic [64*N-1:0] words32(input int base);
        logic [64*N-1:0] d;
        for (int k = 0; k < 2*N; k++) d[32*k +: 32] = 32'(base + k);
        return d;
    endfunction

    function automatic logic [64*N-1:0] lanes64();
        logic [64*N-1:0] d;
        for (int i = 0; i < N; i++) d[64*i +: 64] = 64'(i + 1);
        return d;
    endfunction

    function automatic logic [64*N-1:0] rnd_data();
        logic [64*N-1:0] d;
        for (int k = 0; k < 2*N; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic            acc;
        logic [64*N-1:0] d;
        logic [8*N-1:0]  k;
        logic [8*N-1:0]  all_ones;
        type_width_t     t;

        all_ones = '1;
        @(negedge clk);
        #1;
        check("rst_valid", 1024'(out_valid), 1024'(0));
        check("rst_last", 1024'(out_last), 1024'(0));
        check("rst_keep", 1024'(out_keep), 1024'(0));
        check("rst_data", 1024'(out_data), 1024'(0));
        check("rst_tready", 1024'(tready), 1024'(1));
        @(negedge clk);
        rst_n = 1'b1;

        rmode = 0;
        send(lanes64(), all_ones, 1'b1, BIT64);
        drain();
        send(words32(0), all_ones, 1'b1, BIT32);
        drain();
        send(words32(0), 64'h0000_0000_0000_FFFF, 1'b1, BIT32);
        drain();
        d = words32(0);
        d[31:0] = 32'hFFFF_FFFF;
        send(d, all_ones, 1'b0, BIT32);
        drain();
        send(words32(5), '0, 1'b1, BIT32);
        drain();

        rmode = 1;
        for (int b = 0; b < 4; b++) send(words32(16*b), all_ones, b == 3, BIT64);
        drain();
        for (int b = 0; b < 3; b++) send(words32(100*b), all_ones, b == 2, BIT32);
        drain();

        // Reset while the upper sub-beat is presented.
        rmode = 0;
        send(words32(40), all_ones, 1'b1, BIT32);
        step(acc);
        rmode = 3;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 1024'(out_valid), 1024'(0));
        check("async_rst_tready", 1024'(tready), 1024'(1));
        exp_q.delete();
        stalled = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(acc);
        rmode = 0;
        send(lanes64(), all_ones, 1'b1, BIT64);
        drain();

        rmode = 2;
        for (int b = 0; b < 400; b++) begin
            d = rnd_data();
            case ($urandom_range(0, 3))
                0: k = all_ones;
                1: k = {32'h0, $urandom};
                2: k = '0;
                default: k = {$urandom, $urandom};
            endcase
            t = ($urandom_range(0, 1) != 0) ? BIT64 : BIT32;
            send(d, k, $urandom_range(0, 1) != 0, t);
            if ($urandom_range(0, 4) == 0) step(acc);
        end
        drain();
        rmode = 0;
        step(acc);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
